cnn_batch_sequencer: RTL and testbench

- Hardware initiator for the cnn_top start/done/prediction handshake; replaces the bench-driven start pulse with an on-chip sequencer.
- Runs a batch of N back-to-back inferences: one start pulse per image, wait for done, capture the 1-bit prediction, tally results.
- Sits between the host/control register block and cnn_top; reports per-batch counts, a prediction history and a completion pulse.

---
 rtl/cnn_batch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cnn_batch_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_batch_sequencer.sv
// cnn_batch_sequencer: on-chip initiator running batches of cnn_top inferences.
// Optional WAIT-state watchdog enabled by defining CNN_SEQ_TIMEOUT_EN.
module cnn_batch_sequencer #(
    parameter int MAX_IMAGES     = 16,
    parameter int HIST_W         = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              batch_go,
    input  logic [7:0]        batch_len,
    input  logic              abort,
    output logic              cnn_start,
    input  logic              cnn_done,
    input  logic              cnn_prediction,
    output logic              busy,
    output logic              batch_done,
    output logic [7:0]        img_index,
    output logic [7:0]        pos_count,
    output logic [7:0]        neg_count,
    output logic [HIST_W-1:0] pred_history,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_FIN
    } state_t;

    localparam logic [7:0] MAX_LEN = 8'(MAX_IMAGES);

    state_t     state;
    logic [7:0] len;
    logic       done_q;
    logic       accept;
    logic       expire;
    logic [7:0] idx_nxt;

    assign accept  = cnn_done & ~done_q;
    assign idx_nxt = img_index + 8'd1;

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wdog;

    assign expire = (wdog == TO_LAST);

    // Watchdog: counts WAIT cycles and flags a cnn_top that never answers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_IDLE && batch_go)
                timeout_err <= 1'b0;
            else if (state == S_WAIT && !abort && !accept && expire)
                timeout_err <= 1'b1;
            if (state != S_WAIT)
                wdog <= '0;
            else if (!expire)
                wdog <= wdog + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |32'(TIMEOUT_CYCLES);
    assign expire         = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // Registered copy of cnn_done so only its rising edge is acted on.
    always_ff @(posedge clk) begin
        if (reset)
            done_q <= 1'b0;
        else
            done_q <= cnn_done;
    end

    // Batch sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            len          <= 8'd0;
            cnn_start    <= 1'b0;
            busy         <= 1'b0;
            batch_done   <= 1'b0;
            img_index    <= 8'd0;
            pos_count    <= 8'd0;
            neg_count    <= 8'd0;
            pred_history <= '0;
        end else if (abort && state != S_IDLE) begin
            state      <= S_IDLE;
            cnn_start  <= 1'b0;
            busy       <= 1'b0;
            batch_done <= 1'b0;
        end else begin
            cnn_start  <= 1'b0;
            batch_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (batch_go) begin
                        img_index    <= 8'd0;
                        pos_count    <= 8'd0;
                        neg_count    <= 8'd0;
                        pred_history <= '0;
                        if (batch_len == 8'd0) begin
                            batch_done <= 1'b1;
                            state      <= S_FIN;
                        end else begin
                            len       <= (batch_len > MAX_LEN) ? MAX_LEN : batch_len;
                            busy      <= 1'b1;
                            cnn_start <= 1'b1;
                            state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (accept) begin
                        img_index    <= idx_nxt;
                        pred_history <= {pred_history[HIST_W-2:0], cnn_prediction};
                        if (cnn_prediction)
                            pos_count <= pos_count + 8'd1;
                        else
                            neg_count <= neg_count + 8'd1;
                        if (idx_nxt == len) begin
                            batch_done <= 1'b1;
                            state      <= S_FIN;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (expire) begin
                        batch_done <= 1'b1;
                        state      <= S_FIN;
                    end
                end
                S_GAP: begin
                    cnn_start <= 1'b1;
                    state     <= S_START;
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_batch_sequencer.sv
// tb_cnn_batch_sequencer: scoreboard bench with a cnn_top responder model.
// Timeout scenario depends on CNN_SEQ_TIMEOUT_EN.
module tb_cnn_batch_sequencer;

    localparam int HW = 16;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          batch_go;
    logic [7:0]    batch_len;
    logic          abort;
    logic          cnn_start;
    logic          cnn_done = 1'b0;
    logic          cnn_prediction = 1'b0;
    logic          busy;
    logic          batch_done;
    logic [7:0]    img_index;
    logic [7:0]    pos_count;
    logic [7:0]    neg_count;
    logic [HW-1:0] pred_history;
    logic          timeout_err;

    cnn_batch_sequencer #(
        .MAX_IMAGES(16),
        .HIST_W(HW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .batch_go(batch_go),
        .batch_len(batch_len),
        .abort(abort),
        .cnn_start(cnn_start),
        .cnn_done(cnn_done),
        .cnn_prediction(cnn_prediction),
        .busy(busy),
        .batch_done(batch_done),
        .img_index(img_index),
        .pos_count(pos_count),
        .neg_count(neg_count),
        .pred_history(pred_history),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int starts;
        int pos;
        int neg;
        int hist;
        int idx;
        int terr;
        int busy;
        int kind;
        int cyc;
    } exp_t;

    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit preds[64];
    int hold_mode = 0;
    int hang_img = -1;
    int delay_fixed = 0;
    int img_in_batch = 0;
    int start_cnt = 0;
    int go_cyc = 0;
    int last_rise = 0;
    int last_start = 0;
    int done_cnt = 0;
    int cd = 0;
    int cur = 0;
    bit pending = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // cnn_top responder: done rises a delay after each start.
    always @(negedge clk) begin
        if (cnn_done && hold_mode == 0) cnn_done = 1'b0;
        if (cnn_start) begin
            if (img_in_batch == 0) chk("first_start_latency", cyc, go_cyc + 1);
            else chk("start_spacing", cyc, last_rise + 2);
            cur = img_in_batch;
            img_in_batch++;
            start_cnt++;
            last_start = cyc;
            cd = (delay_fixed > 0) ? delay_fixed : int'($urandom_range(4, 25));
            pending = (cur != hang_img);
        end else if (pending) begin
            cd--;
            if (cd == 2) cnn_done = 1'b0;
            if (cd == 0) begin
                cnn_done = 1'b1;
                cnn_prediction = preds[cur];
                last_rise = cyc;
                pending = 1'b0;
            end
        end
    end

    // Monitor: every batch_done pops one expected batch result.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && batch_done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                chk("unexpected_batch_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("start_count", start_cnt, e.starts);
                chk("pos_count", int'(pos_count), e.pos);
                chk("neg_count", int'(neg_count), e.neg);
                chk("pred_history", int'(pred_history), e.hist);
                chk("img_index", int'(img_index), e.idx);
                chk("timeout_err", int'(timeout_err), e.terr);
                chk("busy_at_done", int'(busy), e.busy);
                if (e.kind == 1) chk("done_cycle", cyc, e.cyc);
                else if (e.kind == 2) chk("timeout_cycle", cyc, last_start + TO + 1);
                else chk("done_after_last", cyc, last_rise + 1);
            end
        end
    end

    function automatic exp_t ref_batch(int len, int hang);
        exp_t e;
        int n;
        int ran;
        e = '{default: 0};
        n = (len > 16) ? 16 : len;
        ran = (hang >= 0 && hang < n) ? hang : n;
        for (int i = 0; i < ran; i++) begin
            if (preds[i]) e.pos++;
            else e.neg++;
            e.hist = ((e.hist << 1) | int'(preds[i])) & 32'hFFFF;
        end
        e.idx = ran;
        e.terr = (ran < n) ? 1 : 0;
        e.starts = (ran < n) ? ran + 1 : n;
        e.busy = (n > 0) ? 1 : 0;
        e.kind = (n == 0) ? 1 : ((ran < n) ? 2 : 0);
        return e;
    endfunction

    task automatic prep(int hold, int hang, bit rnd);
        if (rnd)
            for (int i = 0; i < 64; i++) preds[i] = 1'($urandom_range(0, 1));
        hold_mode = hold;
        hang_img = hang;
        img_in_batch = 0;
        start_cnt = 0;
    endtask

    task automatic run_batch(int len, int hold, int hang, bit rnd, bit mid_go);
        exp_t e;
        int d0;
        int n;
        prep(hold, hang, rnd);
        e = ref_batch(len, hang);
        go_cyc = cyc;
        e.cyc = cyc + 1;
        sbq.push_back(e);
        batch_go = 1'b1;
        batch_len = 8'(len);
        d0 = done_cnt;
        step();
        batch_go = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            if (mid_go && n == 30) begin
                chk("busy_mid_batch", int'(busy), 1);
                batch_go = 1'b1;
                batch_len = 8'd3;
            end else begin
                batch_go = 1'b0;
            end
            step();
            n++;
        end
        batch_go = 1'b0;
        if (done_cnt == d0) begin
            chk("batch_done_wait", 0, 1);
            sbq.delete();
        end
        step();
        chk("busy_after_done", int'(busy), 0);
        chk("start_idle", int'(cnn_start), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        int p2;
        reset = 1'b1;
        batch_go = 1'b0;
        batch_len = 8'd0;
        abort = 1'b0;
        repeat (3) step();
        chk("rst_cnn_start", int'(cnn_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_batch_done", int'(batch_done), 0);
        chk("rst_img_index", int'(img_index), 0);
        chk("rst_pos", int'(pos_count), 0);
        chk("rst_neg", int'(neg_count), 0);
        chk("rst_hist", int'(pred_history), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        reset = 1'b0;
        step();

        preds[0] = 1'b1;
        preds[1] = 1'b0;
        preds[2] = 1'b1;
        delay_fixed = 20;
        run_batch(3, 0, -1, 1'b0, 1'b0);
        chk("t1_pos", int'(pos_count), 2);
        chk("t1_neg", int'(neg_count), 1);
        chk("t1_hist", int'(pred_history[2:0]), 5);
        chk("t1_idx", int'(img_index), 3);
        delay_fixed = 0;

        run_batch(0, 0, -1, 1'b1, 1'b0);
        chk("t2_idx", int'(img_index), 0);

        run_batch(40, 0, -1, 1'b1, 1'b1);
        chk("t3_idx", int'(img_index), 16);

        run_batch(5, 1, -1, 1'b1, 1'b0);
        run_batch(16, 1, -1, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++)
            run_batch(int'($urandom_range(0, 20)), int'($urandom_range(0, 1)),
                      -1, 1'b1, 1'b0);

        prep(0, -1, 1'b1);
        p2 = int'(preds[0]) + int'(preds[1]);
        go_cyc = cyc;
        d0 = done_cnt;
        batch_go = 1'b1;
        batch_len = 8'd5;
        step();
        batch_go = 1'b0;
        n = 0;
        while (start_cnt < 3 && n < 1000) begin
            step();
            n++;
        end
        chk("t5_reach_third", start_cnt, 3);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_idx", int'(img_index), 2);
        chk("t5_start", int'(cnn_start), 0);
        chk("t5_pos", int'(pos_count), p2);
        chk("t5_neg", int'(neg_count), 2 - p2);
        repeat (40) step();
        chk("t5_no_done", done_cnt, d0);
        run_batch(4, 0, -1, 1'b1, 1'b0);

`ifdef CNN_SEQ_TIMEOUT_EN
        run_batch(4, 0, 1, 1'b1, 1'b0);
        chk("t6_terr", int'(timeout_err), 1);
        chk("t6_idx", int'(img_index), 1);
        run_batch(2, 0, -1, 1'b1, 1'b0);
        chk("t6_terr_cleared", int'(timeout_err), 0);
`else
        prep(0, 1, 1'b1);
        go_cyc = cyc;
        d0 = done_cnt;
        batch_go = 1'b1;
        batch_len = 8'd4;
        step();
        batch_go = 1'b0;
        repeat (300) step();
        chk("t6_busy_hold", int'(busy), 1);
        chk("t6_terr_zero", int'(timeout_err), 0);
        chk("t6_idx", int'(img_index), 1);
        chk("t6_no_done", done_cnt, d0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
`endif

        prep(0, -1, 1'b1);
        go_cyc = cyc;
        batch_go = 1'b1;
        batch_len = 8'd6;
        step();
        batch_go = 1'b0;
        n = 0;
        while (start_cnt < 2 && n < 1000) begin
            step();
            n++;
        end
        reset = 1'b1;
        step();
        chk("rst_mid_start", int'(cnn_start), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_idx", int'(img_index), 0);
        chk("rst_mid_pos", int'(pos_count), 0);
        chk("rst_mid_done", int'(batch_done), 0);
        reset = 1'b0;
        repeat (40) step();
        run_batch(3, 0, -1, 1'b1, 1'b0);

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
